// File: rtl/wb_stage.sv
// Write-back stage feeding the 32x64 register file write port.
// Registers ALU results, waits for load data with a timeout, and honours flush.
module wb_stage #(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_wen,
  input  logic [4:0]  in_rd,
  input  logic [2:0]  in_ppp,
  input  logic        in_is_load,
  input  logic [63:0] in_alu,
  input  logic        dmem_rvalid,
  input  logic [63:0] dmem_rdata,
  input  logic        flush,
  output logic        stall_out,
  output logic        writen_en,
  output logic [4:0]  write_address,
  output logic [63:0] data_in,
  output logic [2:0]  ppp,
  output logic        illegal_ppp,
  output logic        timeout_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam logic [7:0] LAST_WAIT = 8'(LOAD_TIMEOUT - 1);

  logic [0:0]  state;
  logic [7:0]  wait_cnt;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_ppp;
  logic        ld_wen;

  logic        accept;
  logic        complete;
  logic        wr_req;
  logic        ex_wen;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_ppp;
  logic [63:0] ex_data;

  assign stall_out = (state == WAIT);
  assign accept    = in_valid && !stall_out && !flush;

  // Select the retiring instruction: a fresh ALU op in IDLE, or the parked load in WAIT.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    ex_wen   = in_wen;
    ex_rd    = in_rd;
    ex_ppp   = in_ppp;
    ex_data  = in_alu;
    complete = accept && !in_is_load;
    if (state == WAIT) begin
      ex_wen   = ld_wen;
      ex_rd    = ld_rd;
      ex_ppp   = ld_ppp;
      ex_data  = dmem_rdata;
      complete = dmem_rvalid && !flush;
    end
  end

  assign wr_req = complete && ex_wen && (ex_rd != 5'd0);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= 8'd0;
      ld_rd         <= 5'd0;
      ld_ppp        <= 3'd0;
      ld_wen        <= 1'b0;
      writen_en     <= 1'b0;
      write_address <= 5'd0;
      data_in       <= 64'd0;
      ppp           <= 3'd0;
      illegal_ppp   <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      writen_en   <= wr_req && (ex_ppp <= 3'd4);
      illegal_ppp <= wr_req && (ex_ppp > 3'd4);
      if (complete) begin
        write_address <= ex_rd;
        data_in       <= ex_data;
        ppp           <= ex_ppp;
      end

      case (state)
        IDLE: begin
          if (accept && in_is_load) begin
            state    <= WAIT;
            wait_cnt <= 8'd0;
            ld_rd    <= in_rd;
            ld_ppp   <= in_ppp;
            ld_wen   <= in_wen;
          end
        end
        WAIT: begin
          if (flush || dmem_rvalid) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == LAST_WAIT) begin
            // Load data never came back: abandon it and flag the loss.
            state       <= IDLE;
            wait_cnt    <= 8'd0;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vector table, hand sequences for timeout/reset,
// then randomized traffic against a cycle-number based reference model.
module tb_wb_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_wen, in_is_load, dmem_rvalid, flush;
  logic [4:0]  in_rd;
  logic [2:0]  in_ppp;
  logic [63:0] in_alu, dmem_rdata;
  logic        stall_out, writen_en, illegal_ppp, timeout_err;
  logic [4:0]  write_address;
  logic [63:0] data_in;
  logic [2:0]  ppp;

  int checks = 0;
  int failures = 0;

  wb_stage #(.LOAD_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_wen(in_wen), .in_rd(in_rd),
    .in_ppp(in_ppp), .in_is_load(in_is_load), .in_alu(in_alu),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .flush(flush),
    .stall_out(stall_out), .writen_en(writen_en), .write_address(write_address),
    .data_in(data_in), .ppp(ppp), .illegal_ppp(illegal_ppp), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld, ld, wen;
    logic [4:0]  rd;
    logic [2:0]  pp;
    logic [63:0] alu;
    logic        rv;
    logic [63:0] rdata;
    logic        fl;
    logic        e_stall, e_wen;
    logic [4:0]  e_addr;
    logic [63:0] e_data;
    logic [2:0]  e_ppp;
    logic        e_ill;
  } vec_t;

  function automatic vec_t v(logic vld, logic ld, logic wen, logic [4:0] rd, logic [2:0] pp,
                             logic [63:0] alu, logic rv, logic [63:0] rdata, logic fl,
                             logic e_stall, logic e_wen, logic [4:0] e_addr,
                             logic [63:0] e_data, logic [2:0] e_ppp, logic e_ill);
    vec_t r;
    r.vld = vld; r.ld = ld; r.wen = wen; r.rd = rd; r.pp = pp; r.alu = alu;
    r.rv = rv; r.rdata = rdata; r.fl = fl;
    r.e_stall = e_stall; r.e_wen = e_wen; r.e_addr = e_addr;
    r.e_data = e_data; r.e_ppp = e_ppp; r.e_ill = e_ill;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic vld, input logic ld, input logic wen, input logic [4:0] rd,
                        input logic [2:0] pp, input logic [63:0] alu, input logic rv,
                        input logic [63:0] rdata, input logic fl);
    in_valid = vld; in_is_load = ld; in_wen = wen; in_rd = rd; in_ppp = pp;
    in_alu = alu; dmem_rvalid = rv; dmem_rdata = rdata; flush = fl;
  endtask

  task automatic idle_in();
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 64'd0, 1'b0, 64'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state: a pending load is described by its latched fields
  // and the absolute cycle by which data must arrive.
  logic        m_pend, m_terr, m_wen, m_ill;
  logic [4:0]  m_addr, l_rd;
  logic [63:0] m_data;
  logic [2:0]  m_ppp, l_ppp;
  logic        l_wen;
  int          cyc, deadline;

  task automatic m_retire(input logic wen, input logic [4:0] rd, input logic [2:0] pp,
                          input logic [63:0] d);
    m_addr = rd; m_data = d; m_ppp = pp;
    if (wen && rd != 0) begin
      if (pp <= 3'd4) m_wen = 1'b1;
      else            m_ill = 1'b1;
    end
  endtask

  task automatic m_step();
    m_wen = 1'b0; m_ill = 1'b0;
    if (reset) begin
      m_pend = 1'b0; m_terr = 1'b0; m_addr = 0; m_data = 0; m_ppp = 0;
    end else if (m_pend) begin
      if (flush) m_pend = 1'b0;
      else if (dmem_rvalid) begin
        m_retire(l_wen, l_rd, l_ppp, dmem_rdata);
        m_pend = 1'b0;
      end else if (cyc == deadline) begin
        m_pend = 1'b0; m_terr = 1'b1;
      end
    end else if (in_valid && !flush) begin
      if (in_is_load) begin
        m_pend = 1'b1; deadline = cyc + TO;
        l_rd = in_rd; l_ppp = in_ppp; l_wen = in_wen;
      end else m_retire(in_wen, in_rd, in_ppp, in_alu);
    end
    cyc++;
  endtask

  vec_t tbl[22];

  initial begin
    logic [63:0] a_val, b_val;
    a_val = 64'h0123456789ABCDEF;
    b_val = 64'hFFFF0000FFFF0000;

    reset = 1'b1;
    idle_in();
    tick();
    tick();
    check("rst_stall", stall_out, 0);
    check("rst_wen", writen_en, 0);
    check("rst_addr", write_address, 0);
    check("rst_data", data_in, 0);
    check("rst_ppp", ppp, 0);
    check("rst_ill", illegal_ppp, 0);
    check("rst_terr", timeout_err, 0);
    reset = 1'b0;

    tbl[0]  = v(1,0,1,5,0,a_val,0,0,0,            0,1,5,a_val,0,0);
    tbl[1]  = v(0,0,0,0,0,0,0,0,0,                0,0,5,a_val,0,0);
    tbl[2]  = v(1,1,1,7,3,64'h77,0,0,0,           0,0,5,a_val,0,0);
    tbl[3]  = v(0,0,0,0,0,0,0,0,0,                1,0,5,a_val,0,0);
    tbl[4]  = v(0,0,0,0,0,0,0,0,0,                1,0,5,a_val,0,0);
    tbl[5]  = v(0,0,0,0,0,0,1,b_val,0,            1,1,7,b_val,3,0);
    tbl[6]  = v(1,0,1,3,1,64'h55,0,0,0,           0,1,3,64'h55,1,0);
    tbl[7]  = v(1,0,1,3,0,64'h99,0,0,1,           0,0,3,64'h55,1,0);
    tbl[8]  = v(1,1,1,10,2,0,0,0,0,               0,0,3,64'h55,1,0);
    tbl[9]  = v(0,0,0,0,0,0,1,64'hDEAD,1,         1,0,3,64'h55,1,0);
    tbl[10] = v(0,0,0,0,0,0,1,64'hBEEF,0,         0,0,3,64'h55,1,0);
    tbl[11] = v(1,0,1,9,6,64'h1111,0,0,0,         0,0,9,64'h1111,6,1);
    tbl[12] = v(1,0,1,0,0,64'h2222,0,0,0,         0,0,0,64'h2222,0,0);
    tbl[13] = v(0,0,0,0,0,0,0,0,0,                0,0,0,64'h2222,0,0);
    for (int i = 1; i <= 4; i++)
      tbl[13+i] = v(1,0,1,5'(i),0,64'h100+64'(i),0,0,0, 0,1,5'(i),64'h100+64'(i),0,0);
    tbl[18] = v(0,0,0,0,0,0,0,0,0,                0,0,4,64'h104,0,0);
    tbl[19] = v(1,1,1,12,7,0,0,0,0,               0,0,4,64'h104,0,0);
    tbl[20] = v(0,0,0,0,0,0,1,64'hABC,0,          1,0,12,64'hABC,7,1);
    tbl[21] = v(0,0,0,0,0,0,0,0,0,                0,0,12,64'hABC,7,0);

    for (int i = 0; i < 22; i++) begin
      set_in(tbl[i].vld, tbl[i].ld, tbl[i].wen, tbl[i].rd, tbl[i].pp, tbl[i].alu,
             tbl[i].rv, tbl[i].rdata, tbl[i].fl);
      #1;
      check($sformatf("v%0d_stall", i), stall_out, tbl[i].e_stall);
      tick();
      check($sformatf("v%0d_wen", i), writen_en, tbl[i].e_wen);
      check($sformatf("v%0d_addr", i), write_address, tbl[i].e_addr);
      check($sformatf("v%0d_data", i), data_in, tbl[i].e_data);
      check($sformatf("v%0d_ppp", i), ppp, tbl[i].e_ppp);
      check($sformatf("v%0d_ill", i), illegal_ppp, tbl[i].e_ill);
      check($sformatf("v%0d_terr", i), timeout_err, 0);
    end

    // Lost load: stall for TO cycles, then sticky timeout, no write.
    set_in(1, 1, 1, 5'd20, 3'd0, 64'd0, 0, 64'd0, 0);
    tick();
    idle_in();
    for (int i = 0; i < TO; i++) begin
      #1;
      check("to_stall_hi", stall_out, 1);
      tick();
      check("to_wen", writen_en, 0);
      check("to_terr", timeout_err, (i == TO - 1) ? 1 : 0);
    end
    set_in(0, 0, 0, 5'd0, 3'd0, 64'd0, 1, 64'h5A5A, 0);
    #1;
    check("to_stall_lo", stall_out, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_wen_late", writen_en, 0);
      check("to_terr_sticky", timeout_err, 1);
    end
    reset = 1'b1;
    idle_in();
    tick();
    reset = 1'b0;
    check("to_terr_cleared", timeout_err, 0);

    // Reset in the middle of a load wait.
    set_in(1, 1, 1, 5'd6, 3'd1, 64'd0, 0, 64'd0, 0);
    tick();
    idle_in();
    #1;
    check("rw_stall", stall_out, 1);
    reset = 1'b1;
    dmem_rvalid = 1'b1;
    tick();
    reset = 1'b0;
    idle_in();
    check("rw_stall_after", stall_out, 0);
    check("rw_wen", writen_en, 0);
    check("rw_addr", write_address, 0);
    tick();
    check("rw_wen_next", writen_en, 0);

    // Randomized traffic against the reference model (starts from IDLE after reset).
    m_pend = 0; m_terr = 0; m_addr = 0; m_data = 0; m_ppp = 0; m_wen = 0; m_ill = 0;
    l_rd = 0; l_ppp = 0; l_wen = 0; cyc = 0; deadline = 0;
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] rd;
      logic [2:0] pp;
      rd = 5'($urandom_range(0, 31));
      pp = 3'($urandom_range(0, 7));
      if (rd == 0) pp = 3'(pp % 5);
      reset = ($urandom_range(0, 199) == 0);
      set_in($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 8,
             rd, pp, {$urandom, $urandom}, $urandom_range(0, 3) == 0,
             {$urandom, $urandom}, $urandom_range(0, 11) == 0);
      #1;
      check("r_stall", stall_out, m_pend);
      m_step();
      tick();
      check("r_wen", writen_en, m_wen);
      check("r_ill", illegal_ppp, m_ill);
      check("r_terr", timeout_err, m_terr);
      check("r_addr", write_address, m_addr);
      check("r_data", data_in, m_data);
      check("r_ppp", ppp, m_ppp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
